// File: rtl/anfsqrt_square_recon.sv
// anfsqrt_square_recon: rebuilds a radicand from a root (and, optionally, a
// remainder) by squaring the root with a radix-4 shift-add loop, two root
// bits per clock. ITERS = (IN_W+1)/2 busy cycles per operation.
// Optional feature macro: ANFSQ_ADD_REM_EN adds the rem port and seeds the
// accumulator with it, so square = root*root + rem.
module anfsqrt_square_recon #(
  parameter int IN_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   root,
`ifdef ANFSQ_ADD_REM_EN
  input  logic [IN_W:0]     rem,
`endif
  output logic              busy,
  output logic              done,
  output logic [2*IN_W-1:0] square
);

  localparam int OUT_W = 2 * IN_W;
  localparam int ITERS = (IN_W + 1) / 2;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   mcand_q, mcand_d;
  logic [IN_W-1:0]    mult_q, mult_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   square_q, square_d;
  logic [OUT_W-1:0]   acc_seed;
  logic [OUT_W-1:0]   acc_next;
  logic               last_iter;

  // One radix-4 step: add the multiplicand once and/or twice depending on
  // the two lowest multiplier bits. Sums wrap at OUT_W bits.
  function automatic logic [OUT_W-1:0] acc_step(input logic [OUT_W-1:0] acc,
                                                input logic [OUT_W-1:0] mcand,
                                                input logic [1:0]       mbits);
    logic [OUT_W-1:0] p0;
    logic [OUT_W-1:0] p1;
    p0 = mbits[0] ? mcand : '0;
    p1 = mbits[1] ? {mcand[OUT_W-2:0], 1'b0} : '0;
    return acc + p0 + p1;
  endfunction

`ifdef ANFSQ_ADD_REM_EN
  assign acc_seed = OUT_W'(rem);
`else
  assign acc_seed = '0;
`endif

  assign acc_next  = acc_step(acc_q, mcand_q, mult_q[1:0]);
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  // Next-state logic: accept in IDLE/DONE, iterate in BUSY, publish on the last step.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mult_d   = mult_q;
    cnt_d    = cnt_q;
    square_d = square_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = BUSY;
          acc_d   = acc_seed;
          mcand_d = {{IN_W{1'b0}}, root};
          mult_d  = root;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d   = acc_next;
        mcand_d = {mcand_q[OUT_W-3:0], 2'b00};
        mult_d  = mult_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) begin
          square_d = acc_next;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mult_q   <= '0;
      cnt_q    <= '0;
      square_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mult_q   <= mult_d;
      cnt_q    <= cnt_d;
      square_q <= square_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = (state_q == DONE);
  assign square = square_q;

endmodule
